// File: rtl/adder_bk_pipe_pkg.sv
// Shared types and helpers for the Brent-Kung adder family.
package adder_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;

  // Prefix-cell signal pair: group propagate / group generate.
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Level counts of the Brent-Kung tree.
  typedef struct packed {
    int unsigned up;
    int unsigned dn;
  } bk_lvl_t;

  // Up-sweep spans log2(w) levels; the down-sweep needs one fewer.
  function automatic bk_lvl_t bk_levels(input int unsigned w);
    bk_lvl_t r;
    r.up = $clog2(w);
    r.dn = r.up - 1;
    return r;
  endfunction

endpackage

// File: rtl/adder_bk_pipe_tree.sv
// Brent-Kung carry tree, split so a register can sit between the sweeps.

// Black cell: combines two (G,P) groups into one.
module black_cell
  import adder_pkg::*;
(
  input  pg_t hi_i,
  input  pg_t lo_i,
  output pg_t pg_o
);
  assign pg_o.g = hi_i.g | (hi_i.p & lo_i.g);
  assign pg_o.p = hi_i.p & lo_i.p;
endmodule

// Gray cell: generate-only combine, used where the group reaches bit 0.
module gray_cell
  import adder_pkg::*;
(
  input  pg_t  hi_i,
  input  logic lo_g_i,
  output logic g_o
);
  assign g_o = hi_i.g | (hi_i.p & lo_g_i);
endmodule

// Purely combinational tree. up_o are the power-of-two span groups; the
// down-sweep consumes grp_i (up_o, optionally registered) and produces
// every carry c[i] = G[i:0] (carry-in already folded into bit 0).
module carry_tree_bk_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  pg_t  [WIDTH-1:0] pg_i,
  output pg_t  [WIDTH-1:0] up_o,
  input  pg_t  [WIDTH-1:0] grp_i,
  output logic [WIDTH-1:0] c_o
);
  localparam bk_lvl_t LV = bk_levels(WIDTH);
  localparam int UP = int'(LV.up);
  localparam int DN = int'(LV.dn);

  // Up-sweep: at level l, bit i with (i+1) a multiple of 2^l absorbs the
  // group ending 2^(l-1) bits below it.
  for (genvar l = 0; l <= UP; l++) begin : g_up
    pg_t [WIDTH-1:0] n;
    if (l == 0) begin : g_in
      assign n = pg_i;
    end else begin : g_lvl
      localparam int S = 1 << (l - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (2 * S)) == 0) begin : g_blk
          black_cell u_cell (
            .hi_i (g_up[l-1].n[i]),
            .lo_i (g_up[l-1].n[i-S]),
            .pg_o (n[i])
          );
        end else begin : g_pass
          assign n[i] = g_up[l-1].n[i];
        end
      end
    end
  end
  assign up_o = g_up[UP].n;

  // Down-sweep: fill the mid-span carries from the widest span downwards.
  // The hi operand is never touched by an earlier down level, so it is
  // taken straight from grp_i.
  for (genvar j = 0; j <= DN; j++) begin : g_dn
    logic [WIDTH-1:0] g;
    if (j == 0) begin : g_in
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign g[i] = grp_i[i].g;
      end
    end else begin : g_lvl
      localparam int S = 1 << (UP - j - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((i >= 2 * S) && (((i + 1) % (2 * S)) == S)) begin : g_gry
          gray_cell u_cell (
            .hi_i   (grp_i[i]),
            .lo_g_i (g_dn[j-1].g[i-S]),
            .g_o    (g[i])
          );
        end else begin : g_pass
          assign g[i] = g_dn[j-1].g[i];
        end
      end
    end
  end
  assign c_o = g_dn[DN].g;

endmodule

// File: rtl/adder_bk_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
module adder_bk_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REG_MID = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int LAT = 2 + REG_MID;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (WIDTH & (WIDTH - 1)) != 0
      || TAG_W < 1) begin : g_bad_param
    $error("adder_bk_pipe: WIDTH must be a power of two in 4..64, TAG_W >= 1");
  end

  // ---------------- valid / enable chain ----------------
  logic [LAT-1:0] vld_pipe_q, vld_pipe_d, vld_in, en, ld;

  assign vld_in = {vld_pipe_q[LAT-2:0], valid_i};

  // A stage may advance when the output drains or any stage at or after it
  // is empty; this is the unrolled form of en[k] = !v[k] | en[k+1].
  for (genvar k = 0; k < LAT; k++) begin : g_en
    assign en[k] = ready_i | ~(&vld_pipe_q[LAT-1:k]);
  end

  assign ld         = en & vld_in;
  assign vld_pipe_d = (en & vld_in) | (~en & vld_pipe_q);
  assign ready_o    = en[0];
  assign valid_o    = vld_pipe_q[LAT-1];

  // Valid shift register, cleared on reset so in-flight beats vanish.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_pipe_q <= '0;
    else       vld_pipe_q <= vld_pipe_d;
  end

  // ---------------- stage 0 ----------------
  logic [WIDTH-1:0] b_e, p_d, g_d;
  logic             cin_d;

  // Operand conditioning; carry-in folded into the bit-0 generate.
  always_comb begin
    b_e   = sub_i ? ~b_i : b_i;
    cin_d = sub_i | carry_i;
    p_d   = a_i ^ b_e;
    g_d   = a_i & b_e;
    g_d[0] = g_d[0] | (p_d[0] & cin_d);
  end

  logic [WIDTH-1:0] s0_p_q, s0_g_q;
  logic             s0_cin_q;
  logic [TAG_W-1:0] s0_tag_q;

  // Input register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_p_q   <= '0;
      s0_g_q   <= '0;
      s0_cin_q <= 1'b0;
      s0_tag_q <= '0;
    end else if (ld[0]) begin
      s0_p_q   <= p_d;
      s0_g_q   <= g_d;
      s0_cin_q <= cin_d;
      s0_tag_q <= tag_i;
    end
  end

  // ---------------- prefix tree ----------------
  pg_t  [WIDTH-1:0] s0_pg, up_pg, mid_pg;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] mid_p;
  logic             mid_cin;
  logic [TAG_W-1:0] mid_tag;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pg
    assign s0_pg[i].p = s0_p_q[i];
    assign s0_pg[i].g = s0_g_q[i];
  end

  carry_tree_bk_n #(.WIDTH(WIDTH)) u_tree (
    .pg_i  (s0_pg),
    .up_o  (up_pg),
    .grp_i (mid_pg),
    .c_o   (carry)
  );

  if (REG_MID != 0) begin : g_mid
    pg_t  [WIDTH-1:0] s1_grp_q;
    logic [WIDTH-1:0] s1_p_q;
    logic             s1_cin_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Mid-tree register: up-sweep groups plus the stage-0 sideband.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_grp_q <= '0;
        s1_p_q   <= '0;
        s1_cin_q <= 1'b0;
        s1_tag_q <= '0;
      end else if (ld[1]) begin
        s1_grp_q <= up_pg;
        s1_p_q   <= s0_p_q;
        s1_cin_q <= s0_cin_q;
        s1_tag_q <= s0_tag_q;
      end
    end

    assign mid_pg  = s1_grp_q;
    assign mid_p   = s1_p_q;
    assign mid_cin = s1_cin_q;
    assign mid_tag = s1_tag_q;
  end else begin : g_nomid
    assign mid_pg  = up_pg;
    assign mid_p   = s0_p_q;
    assign mid_cin = s0_cin_q;
    assign mid_tag = s0_tag_q;
  end

  // ---------------- output stage ----------------
  logic [WIDTH-1:0] sum_d;
  logic             carry_d, ovf_d;

  // Sum and flags: carry into bit i is c[i-1], or c_in for bit 0.
  always_comb begin
    sum_d   = mid_p ^ {carry[WIDTH-2:0], mid_cin};
    carry_d = carry[WIDTH-1];
    ovf_d   = carry[WIDTH-1] ^ carry[WIDTH-2];
  end

  // Output register; holds while stalled because ld is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_o   <= '0;
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
      tag_o   <= '0;
    end else if (ld[LAT-1]) begin
      sum_o   <= sum_d;
      carry_o <= carry_d;
      ovf_o   <= ovf_d;
      tag_o   <= mid_tag;
    end
  end

endmodule
